pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 67 ++++++
 tb/tb_pipe_reg_chain.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Parameterised register pipeline with per-stage valid bit, stall enable, flush and occupancy count.
// Build option PIPE_FLUSH_CLEAR_EN: when defined, flush also reloads RESET_VAL into every data stage.
module pipe_reg_chain #(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          DEPTH     = 2,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] data_r;
    logic [DEPTH-1:0][WIDTH-1:0] data_n;
    logic [DEPTH-1:0]            valid_r;
    logic [DEPTH-1:0]            valid_n;

    // Next-state: flush beats enable; bubble data still shifts so the datapath needs no gating.
    always_comb begin
        data_n  = data_r;
        valid_n = valid_r;
        if (flush) begin
            valid_n = '0;
`ifdef PIPE_FLUSH_CLEAR_EN
            data_n  = {DEPTH{RESET_VAL}};
`endif
        end else if (en) begin
            data_n[0]  = d;
            valid_n[0] = in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_n[i]  = data_r[i-1];
                valid_n[i] = valid_r[i-1];
            end
        end
    end

    // Stage registers; asynchronous reset discards everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= {DEPTH{RESET_VAL}};
            valid_r <= '0;
        end else begin
            data_r  <= data_n;
            valid_r <= valid_n;
        end
    end

    assign q         = data_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];

    // Population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_r[i]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=32, DEPTH=3, RESET_VAL=AAAA5555) against a queue-based item model.
module tb_pipe_reg_chain;

    localparam int unsigned W  = 32;
    localparam int unsigned DP = 3;
    localparam logic [31:0] RV = 32'hAAAA5555;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic [31:0] d;
    logic [31:0] q;
    logic        out_valid;
    logic [1:0]  occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: list of in-flight slots, index 0 = newest, DP-1 = output.
    logic [31:0] mq[$];
    logic        mv[$];

    typedef struct {
        logic        en;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic [31:0] q;
        logic        ov;
        int          occ;
    } vec_t;

    vec_t tbl[7];

    pipe_reg_chain #(.WIDTH(W), .DEPTH(DP), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q), .out_valid(out_valid), .occupancy(occupancy)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_occ();
        int c = 0;
        foreach (mv[i]) c += int'(mv[i]);
        return c;
    endfunction

    task automatic model_reset();
        mq = {};
        mv = {};
        for (int i = 0; i < int'(DP); i++) begin
            mq.push_back(RV);
            mv.push_back(1'b0);
        end
    endtask

    task automatic model_step(input logic e, input logic f, input logic v, input logic [31:0] dd);
        if (f) begin
            foreach (mv[i]) mv[i] = 1'b0;
`ifdef PIPE_FLUSH_CLEAR_EN
            foreach (mq[i]) mq[i] = RV;
`endif
        end else if (e) begin
            mq.push_front(dd);
            mv.push_front(v);
            void'(mq.pop_back());
            void'(mv.pop_back());
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge, compare with model.
    task automatic step(input string tag, input logic e, input logic f, input logic v, input logic [31:0] dd);
        @(negedge clk);
        en = e; flush = f; in_valid = v; d = dd;
        @(posedge clk);
        #1;
        model_step(e, f, v, dd);
        chk({tag, ".q"}, q, mq[DP-1]);
        chk({tag, ".ov"}, 32'(out_valid), 32'(mv[DP-1]));
        chk({tag, ".occ"}, 32'(occupancy), 32'(model_occ()));
    endtask

    initial begin
        logic [31:0] prev_q;

        reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = '0;
        model_reset();
        #5;
        chk("rst.q", q, RV);
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill, drain with bubbles, one stall.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, RV,           1'b0, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h00000000, RV,           1'b0, 2};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'hC0DE0001, 32'hFFFFFFFF, 1'b1, 3};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b1, 2};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h00000055, 32'h00000000, 1'b1, 2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h00000001, 32'hC0DE0001, 1'b1, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h00000002, 32'hDEADBEEF, 1'b0, 0};
        for (int i = 0; i < 7; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].d);
            chk($sformatf("tbl%0d.q_const", i), q, tbl[i].q);
            chk($sformatf("tbl%0d.ov_const", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d.occ_const", i), 32'(occupancy), 32'(tbl[i].occ));
        end

        // Three items in flight, stall four edges, then drain in order.
        step("ld1", 1'b1, 1'b0, 1'b1, 32'hA1A1A1A1);
        step("ld2", 1'b1, 1'b0, 1'b1, 32'hA2A2A2A2);
        step("ld3", 1'b1, 1'b0, 1'b1, 32'hA3A3A3A3);
        for (int i = 0; i < 4; i++) begin
            step("stall", 1'b0, 1'b0, 1'b1, $urandom);
            chk("stall.q", q, 32'hA1A1A1A1);
            chk("stall.ov", 32'(out_valid), 32'd1);
            chk("stall.occ", 32'(occupancy), 32'd3);
        end
        step("drn1", 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drn1.q", q, 32'hA2A2A2A2);
        step("drn2", 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drn2.q", q, 32'hA3A3A3A3);
        step("drn3", 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drn3.ov", 32'(out_valid), 32'd0);

        // Flush with a competing valid input: nothing survives, new item dropped.
        step("f_ld1", 1'b1, 1'b0, 1'b1, 32'h11111111);
        step("f_ld2", 1'b1, 1'b0, 1'b1, 32'h22222222);
        prev_q = q;
        step("flush", 1'b1, 1'b1, 1'b1, 32'h33333333);
        chk("flush.ov", 32'(out_valid), 32'd0);
        chk("flush.occ", 32'(occupancy), 32'd0);
`ifdef PIPE_FLUSH_CLEAR_EN
        chk("flush.q", q, RV);
`else
        chk("flush.q", q, prev_q);
`endif
        for (int i = 0; i < 3; i++) begin
            step("postflush", 1'b1, 1'b0, 1'b0, 32'h44444444);
            chk("postflush.no33", 32'(q == 32'h33333333), 32'd0);
            chk("postflush.ov", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-cycle with two items in flight.
        step("r_ld1", 1'b1, 1'b0, 1'b1, 32'h5A5A0001);
        step("r_ld2", 1'b1, 1'b0, 1'b1, 32'h5A5A0002);
        chk("r_pre.occ", 32'(occupancy), 32'd2);
        #4 reset = 1'b1;
        #1;
        chk("arst.q", q, RV);
        chk("arst.ov", 32'(out_valid), 32'd0);
        chk("arst.occ", 32'(occupancy), 32'd0);
        #2 reset = 1'b0;
        model_reset();
        step("after_rst", 1'b1, 1'b0, 1'b1, 32'h77777777);

        // Random traffic against the model.
        for (int i = 0; i < 48; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
